// File: rtl/mac_array_pkg.sv
// Shared types for the MAC array issue/drain scheduler: FSM encoding,
// psum_info field layout and the beat record carried down the pipeline.
package mac_array_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_DRAIN = 2'd2,
    ST_DONE  = 2'd3
  } state_t;

  localparam int INFO_W    = 32;
  localparam int PIX_LSB   = 0;
  localparam int PIX_W     = 16;
  localparam int OC_LSB    = 16;
  localparam int OC_W      = 8;
  localparam int GRP_LSB   = 24;
  localparam int GRP_W     = 6;
  localparam int FIRST_BIT = 30;
  localparam int LAST_BIT  = 31;
  // Wide enough for the largest supported array (64 lanes).
  localparam int SEL_W_MAX = 6;

  typedef struct packed {
    logic                 vld;
    logic [INFO_W-1:0]    info;
    logic [SEL_W_MAX-1:0] identity_sel;
    logic                 identity_vld;
  } beat_t;

  function automatic logic [INFO_W-1:0] pack_info(
    input logic             last_grp,
    input logic             first_grp,
    input logic [GRP_W-1:0] grp,
    input logic [OC_W-1:0]  oc,
    input logic [PIX_W-1:0] pix
  );
    return {last_grp, first_grp, grp, oc, pix};
  endfunction

endpackage

// File: rtl/mac_array_sched_track.sv
// Stallable PIPE_DEPTH-deep shift register of beat records mirroring the
// MAC core pipeline; the tail entry is the beat presented to psum_acc.
module mac_array_sched_track
  import mac_array_pkg::*;
#(
  parameter int PIPE_DEPTH = 4
) (
  input  logic  clk,
  input  logic  rst_n,
  input  logic  adv,
  input  beat_t beat_in,
  output beat_t tail,
  output logic  body_empty
);

  beat_t [PIPE_DEPTH-1:0] sr;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sr <= '0;
    end else if (adv) begin
      sr <= {sr[PIPE_DEPTH-2:0], beat_in};
    end
  end

  assign tail = sr[PIPE_DEPTH-1];

  // Everything upstream of the tail is empty.
  always_comb begin
    body_empty = 1'b1;
    for (int i = 0; i < PIPE_DEPTH - 1; i++) begin
      if (sr[i].vld) body_empty = 1'b0;
    end
  end

endmodule

// File: rtl/mac_array_sched.sv
// Issue/drain scheduler for the MAC array: walks out_ch x in-group x pixel,
// issues imap reads and drains psum beats. Optional MAC_ARRAY_SCHED_PERF_EN.
module mac_array_sched
  import mac_array_pkg::*;
#(
  parameter int ARRAY_NUM  = 32,
  parameter int CH_W       = 8,
  parameter int MAP_W      = 16,
  parameter int ADDR_W     = 32,
  parameter int PIPE_DEPTH = 4
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         conv_start,
  input  logic [CH_W-1:0]              in_ch,
  input  logic [CH_W-1:0]              out_ch,
  input  logic [MAP_W-1:0]             map_size,
  output logic [ADDR_W-1:0]            imap_raddr,
  output logic                         imap_ren,
  output logic                         pipe_en,
  output logic [$clog2(ARRAY_NUM)-1:0] identity_sel,
  output logic                         identity_vld,
  output logic [31:0]                  psum_info,
  output logic                         psum_vld,
  input  logic                         psum_rdy,
  output logic                         busy,
  output logic                         conv_done,
  output logic [31:0]                  stall_cycles
);

  localparam int SEL_W = $clog2(ARRAY_NUM);

  state_t            state;
  logic [CH_W-1:0]   in_ch_q, out_ch_q, n_grp_q;
  logic [MAP_W-1:0]  map_size_q;
  logic [CH_W-1:0]   oc, grp;
  logic [MAP_W-1:0]  pix;
  logic [ADDR_W-1:0] addr;
  logic [CH_W-1:0]   n_grp_calc;
  logic              pix_last, grp_last, oc_last, issue, cfg_ok;
  beat_t             beat_in, tail;
  logic              body_empty;
  logic              sel_unused;

  // Handshake: a beat transfers on a cycle where psum_vld && psum_rdy; an
  // unaccepted beat freezes the whole core, so the tail stays stable.
  assign pipe_en  = !(tail.vld && !psum_rdy);
  assign issue    = (state == ST_ISSUE) && pipe_en;
  assign imap_ren = issue;

  assign n_grp_calc = (in_ch >> SEL_W) + CH_W'(|in_ch[SEL_W-1:0]);
  assign cfg_ok     = (in_ch != '0) && (out_ch != '0) && (map_size != '0);
  assign pix_last   = (pix == map_size_q - MAP_W'(1));
  assign grp_last   = (grp == n_grp_q - CH_W'(1));
  assign oc_last    = (oc == out_ch_q - CH_W'(1));

  always_comb begin
    beat_in = '0;
    if (issue) begin
      beat_in.vld          = 1'b1;
      beat_in.info         = pack_info(grp_last, grp == '0, GRP_W'(grp),
                                       OC_W'(oc), PIX_W'(pix));
      beat_in.identity_sel = SEL_W_MAX'(oc[SEL_W-1:0]);
      beat_in.identity_vld = (grp == (oc >> SEL_W)) && (oc < in_ch_q);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= ST_IDLE;
      in_ch_q    <= '0;
      out_ch_q   <= '0;
      map_size_q <= '0;
      n_grp_q    <= '0;
      oc         <= '0;
      grp        <= '0;
      pix        <= '0;
      addr       <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (conv_start) begin
            in_ch_q    <= in_ch;
            out_ch_q   <= out_ch;
            map_size_q <= map_size;
            n_grp_q    <= n_grp_calc;
            oc         <= '0;
            grp        <= '0;
            pix        <= '0;
            addr       <= '0;
            state      <= cfg_ok ? ST_ISSUE : ST_DONE;
          end
        end
        ST_ISSUE: begin
          if (pipe_en) begin
            if (!pix_last) begin
              pix  <= pix + MAP_W'(1);
              addr <= addr + ADDR_W'(1);
            end else begin
              pix <= '0;
              if (!grp_last) begin
                grp  <= grp + CH_W'(1);
                addr <= addr + ADDR_W'(1);
              end else begin
                // Address restarts for every output channel.
                grp  <= '0;
                addr <= '0;
                if (oc_last) state <= ST_DRAIN;
                else         oc    <= oc + CH_W'(1);
              end
            end
          end
        end
        ST_DRAIN: begin
          if (body_empty && (!tail.vld || psum_rdy)) state <= ST_DONE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  mac_array_sched_track #(.PIPE_DEPTH(PIPE_DEPTH)) u_track (
    .clk        (clk),
    .rst_n      (rst_n),
    .adv        (pipe_en),
    .beat_in    (beat_in),
    .tail       (tail),
    .body_empty (body_empty)
  );

  assign sel_unused   = ^tail.identity_sel;
  assign imap_raddr   = addr;
  assign psum_vld     = tail.vld;
  assign psum_info    = tail.info;
  assign identity_sel = tail.identity_sel[SEL_W-1:0];
  assign identity_vld = tail.identity_vld;
  assign busy         = (state != ST_IDLE);
  assign conv_done    = (state == ST_DONE);

`ifdef MAC_ARRAY_SCHED_PERF_EN
  logic [31:0] stall_cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_cnt <= '0;
    end else if (state == ST_IDLE && conv_start) begin
      stall_cnt <= '0;
    end else if (busy && !pipe_en && stall_cnt != 32'hFFFF_FFFF) begin
      stall_cnt <= stall_cnt + 32'd1;
    end
  end

  assign stall_cycles = stall_cnt;
`else
  assign stall_cycles = '0;
`endif

endmodule
